canvas_snapshot_ctrl: RTL and testbench
=======================================

Name: canvas_snapshot_ctrl

Overview:
- Sequencer and arbiter for the 640x480 1-bit canvas row RAM. The canvas stores one 640-bit word per row.
- Shares the canvas port between two users:
  - the paint engine, which writes single pixels via read-modify-write;
  - a full-canvas snapshot engine, which copies all rows canvas->save RAM (save) or save RAM->canvas (load).
- Sits between the cursor/paint logic, the canvas RAM and the save RAM.

Parameters:
- ROWS, 480, canvas rows.
- COLS, 640, canvas columns; also the row word width.
- AW, 9, row address width; must satisfy 2^AW >= ROWS.

Ports:
- CLOCK_50 input 1: system clock; all state changes on rising edge.
- reset input 1: asynchronous, active-high; clears all state.
- save_req input 1: start snapshot canvas->save RAM. Sampled only in IDLE.
- load_req input 1: start restore save RAM->canvas. Sampled only in IDLE.
- paint_we input 1: pixel write request; held high until paint_ack.
- paint_x input 11: pixel column.
- paint_y input 11: pixel row.
- paint_px input 1: pixel value to write.
- paint_ack output 1: one-cycle pulse; paint request consumed.
- canvas_addr output AW: canvas row address.
- canvas_rdata input COLS: canvas read data, valid 1 cycle after canvas_addr.
- canvas_we output 1: canvas write enable.
- canvas_wdata output COLS: canvas write data.
- save_addr output AW: save RAM row address.
- save_rdata input COLS: save RAM read data, valid 1 cycle after save_addr.
- save_we output 1: save RAM write enable.
- save_wdata output COLS: save RAM write data.
- busy output 1: high while a save or load is in progress.
- done output 1: one-cycle pulse after the last row of a save or load is written.
- save_valid output 1: a complete snapshot exists in the save RAM.

Behaviour:
- Reset values: all outputs 0, row counter 0, state IDLE, save_valid 0.
- Reset asserted mid-operation aborts immediately. Partially written RAM contents are left as-is. save_valid is cleared.
- States: IDLE, P_WR, S_RD, S_WR, L_RD, L_WR, FIN.
- IDLE arbitration, priority save_req > load_req > paint_we:
  - save_req=1: row<=0, canvas_addr<=0, go to S_RD.
  - else load_req=1 and save_valid=1: row<=0, save_addr<=0, go to L_RD.
  - load_req with save_valid=0 is ignored: no busy, no done.
  - else paint_we=1 with paint_x<COLS and paint_y<ROWS: canvas_addr<=paint_y[AW-1:0], latch x/px, go to P_WR.
  - else paint_we=1 out of range: paint_ack pulses next cycle, no RAM access, stay IDLE.
- P_WR:
  - canvas_we=1, canvas_addr unchanged.
  - canvas_wdata = canvas_rdata with bit[paint_x] replaced by paint_px. Bit x corresponds to column x.
  - paint_ack=1 this cycle; return to IDLE.
  - Paint latency: 2 cycles from acceptance to ack. Back-to-back paint writes run at one per 3 cycles, since IDLE takes a cycle.
- S_RD: wait state; canvas read of row is in flight. Go to S_WR.
- S_WR:
  - save_we=1, save_addr=row, save_wdata=canvas_rdata.
  - If row==ROWS-1, go to FIN. Else row+1, canvas_addr<=row+1, go to S_RD.
- L_RD / L_WR: mirror of S_RD / S_WR. Read save RAM at row, write canvas_we/canvas_wdata=save_rdata at canvas_addr=row.
- FIN:
  - done=1 for one cycle; busy=0; return to IDLE.
  - After a save, save_valid<=1. After a load, save_valid is unchanged.
- busy=1 in S_RD, S_WR, L_RD, L_WR. A full save or load takes 2*ROWS cycles plus FIN (961 cycles with default parameters).
- During busy:
  - save_req and load_req are ignored, not queued.
  - paint_we stalls with paint_ack=0. The requester holds x/y/px stable; the request is serviced once IDLE is reached again.
- Write enables never assert outside P_WR, S_WR, L_WR. Only one of canvas_we/save_we is high in any cycle.
- Counter wrap: the row counter never exceeds ROWS-1. No wrap to 0 within an operation.

Test Plan:
- Reset mid-save: assert save_req, let 10 rows copy, pulse reset -> busy=0, done=0, save_valid=0. A subsequent load_req is ignored (busy stays 0).
- Paint write: canvas row 5 all zeros; paint_we with x=3, y=5, px=1 -> cycle 2 shows canvas_we=1, canvas_addr=5, canvas_wdata=...01000 (bit 3 set), paint_ack=1. Then x=3, px=0 clears bit 3.
- Full save: preload canvas row r with pattern {r}; pulse save_req -> 480 save_we pulses at addrs 0..479 with matching data, done pulse at cycle 961, save_valid=1.
- Load after save: modify canvas rows 1-5 via paint, pulse load_req -> canvas_we writes restore rows 0..479 to the saved pattern, done pulses, save_valid stays 1.
- Arbitration: save_req, load_req and paint_we all high in the same IDLE cycle -> save runs. paint_ack stays 0 for the whole save and pulses 2 cycles after FIN returns to IDLE. load_req during busy is dropped.
- Bounds: paint_we with x=640, y=1 and with x=1, y=480 -> paint_ack pulse, no canvas_we. Paint at x=639, y=479 writes bit 639 of row 479.

Source files
------------

// File: rtl/canvas_snapshot_ctrl.sv
// Canvas row-RAM sequencer: arbitrates pixel read-modify-writes against full-canvas save/load copies.
// Paint acks 2 cycles after acceptance; a save/load takes 2*ROWS+1 cycles and stalls paint_we without ack.
module canvas_snapshot_ctrl #(
  parameter int ROWS = 480,
  parameter int COLS = 640,
  parameter int AW   = 9
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            save_req,
  input  logic            load_req,
  input  logic            paint_we,
  input  logic [10:0]     paint_x,
  input  logic [10:0]     paint_y,
  input  logic            paint_px,
  output logic            paint_ack,
  output logic [AW-1:0]   canvas_addr,
  input  logic [COLS-1:0] canvas_rdata,
  output logic            canvas_we,
  output logic [COLS-1:0] canvas_wdata,
  output logic [AW-1:0]   save_addr,
  input  logic [COLS-1:0] save_rdata,
  output logic            save_we,
  output logic [COLS-1:0] save_wdata,
  output logic            busy,
  output logic            done,
  output logic            save_valid
);

  localparam int              XW       = $clog2(COLS);
  localparam logic [10:0]     ROWS_L   = 11'(ROWS);
  localparam logic [10:0]     COLS_L   = 11'(COLS);
  localparam logic [AW-1:0]   LAST_ROW = AW'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, P_WR, S_RD, S_WR, L_RD, L_WR, FIN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] row;
  logic [AW-1:0] caddr;
  logic [XW-1:0] x_q;
  logic          px_q;
  logic          p_rd;
  logic          oor_ack;
  logic          is_save;
  logic          valid_q;

  logic in_range, load_go, paint_go, paint_oor, last;

  // oor_ack blocks re-acceptance while the requester still holds paint_we in the ack cycle
  assign in_range  = (paint_x < COLS_L) && (paint_y < ROWS_L);
  assign load_go   = load_req && valid_q;
  assign paint_go  = paint_we && !oor_ack && in_range;
  assign paint_oor = paint_we && !oor_ack && !in_range;
  assign last      = (row == LAST_ROW);

  assign canvas_addr = caddr;
  assign save_addr   = row;
  assign save_valid  = valid_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    paint_ack    = oor_ack;
    canvas_we    = 1'b0;
    canvas_wdata = '0;
    save_we      = 1'b0;
    save_wdata   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (save_req)      state_n = S_RD;
        else if (load_go)  state_n = L_RD;
        else if (paint_go) state_n = P_WR;
      end
      P_WR: begin
        // first cycle only waits for the row read to return
        if (!p_rd) begin
          canvas_we          = 1'b1;
          canvas_wdata       = canvas_rdata;
          canvas_wdata[x_q]  = px_q;
          paint_ack          = 1'b1;
          state_n            = IDLE;
        end
      end
      S_RD: begin
        busy    = 1'b1;
        state_n = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        save_we    = 1'b1;
        save_wdata = canvas_rdata;
        state_n    = last ? FIN : S_RD;
      end
      L_RD: begin
        busy    = 1'b1;
        state_n = L_WR;
      end
      L_WR: begin
        busy         = 1'b1;
        canvas_we    = 1'b1;
        canvas_wdata = save_rdata;
        state_n      = last ? FIN : L_RD;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      row     <= '0;
      caddr   <= '0;
      x_q     <= '0;
      px_q    <= 1'b0;
      p_rd    <= 1'b0;
      oor_ack <= 1'b0;
      is_save <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      p_rd    <= 1'b0;
      oor_ack <= (state == IDLE) && !save_req && !load_go && paint_oor;
      case (state)
        IDLE: begin
          if (save_req) begin
            row     <= '0;
            caddr   <= '0;
            is_save <= 1'b1;
          end else if (load_go) begin
            row     <= '0;
            caddr   <= '0;
            is_save <= 1'b0;
          end else if (paint_go) begin
            caddr <= paint_y[AW-1:0];
            x_q   <= paint_x[XW-1:0];
            px_q  <= paint_px;
            p_rd  <= 1'b1;
          end
        end
        S_WR, L_WR: begin
          if (!last) begin
            row   <= row + 1'b1;
            caddr <= row + 1'b1;
          end
        end
        FIN: begin
          if (is_save) valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_snapshot_ctrl.sv
// Scoreboarded bench for canvas_snapshot_ctrl with behavioural canvas/save RAMs and a row-level reference model.
module tb_canvas_snapshot_ctrl;
  localparam int ROWS = 480;
  localparam int COLS = 640;
  localparam int AW   = 9;

  typedef struct packed {
    logic            cwe;
    logic            swe;
    logic            ack;
    logic            dn;
    logic [AW-1:0]   addr;
    logic [COLS-1:0] data;
  } ev_t;

  logic            CLOCK_50 = 1'b0;
  logic            reset = 1'b1;
  logic            save_req = 1'b0, load_req = 1'b0, paint_we = 1'b0, paint_px = 1'b0;
  logic [10:0]     paint_x = '0, paint_y = '0;
  logic            paint_ack, canvas_we, save_we, busy, done, save_valid;
  logic [AW-1:0]   canvas_addr, save_addr;
  logic [COLS-1:0] canvas_rdata, canvas_wdata, save_rdata, save_wdata;

  logic            bd_we = 1'b0;
  logic [AW-1:0]   bd_addr = '0;
  logic [COLS-1:0] bd_data = '0;
  logic [COLS-1:0] canvas_mem [512];
  logic [COLS-1:0] save_mem   [512];

  logic [COLS-1:0] ref_canvas [ROWS];
  logic [COLS-1:0] ref_save   [ROWS];
  bit              ref_valid = 0;
  ev_t             exp_q[$];
  int              tests = 0, fails = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  canvas_snapshot_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .save_req(save_req), .load_req(load_req),
    .paint_we(paint_we), .paint_x(paint_x), .paint_y(paint_y), .paint_px(paint_px),
    .paint_ack(paint_ack), .canvas_addr(canvas_addr), .canvas_rdata(canvas_rdata),
    .canvas_we(canvas_we), .canvas_wdata(canvas_wdata), .save_addr(save_addr),
    .save_rdata(save_rdata), .save_we(save_we), .save_wdata(save_wdata),
    .busy(busy), .done(done), .save_valid(save_valid)
  );

  // synchronous RAMs, read data one cycle after address
  always @(posedge CLOCK_50) begin
    if (canvas_we)  canvas_mem[canvas_addr] <= canvas_wdata;
    else if (bd_we) canvas_mem[bd_addr]     <= bd_data;
    canvas_rdata <= canvas_mem[canvas_addr];
    if (save_we) save_mem[save_addr] <= save_wdata;
    save_rdata <= save_mem[save_addr];
  end

  function automatic ev_t mk(input logic c, s, a, d, input int ad, input logic [COLS-1:0] dt);
    ev_t e;
    e.cwe = c; e.swe = s; e.ack = a; e.dn = d;
    e.addr = AW'(ad); e.data = dt;
    return e;
  endfunction

  function automatic logic [COLS-1:0] rnd_row();
    logic [COLS-1:0] v;
    for (int i = 0; i < COLS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    ev_t act, ex;
    forever begin
      @(negedge CLOCK_50);
      if (!reset && (canvas_we || save_we || paint_ack || done)) begin
        act = mk(canvas_we, save_we, paint_ack, done, 0, '0);
        if (canvas_we) begin act.addr = canvas_addr; act.data = canvas_wdata; end
        else if (save_we) begin act.addr = save_addr; act.data = save_wdata; end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got c%0d s%0d a%0d d%0d @%0d, required no event",
                   act.cwe, act.swe, act.ack, act.dn, act.addr);
        end else begin
          ex = exp_q.pop_front();
          if (act !== ex) begin
            fails++;
            $display("FAIL event: got c%0d s%0d a%0d d%0d @%0d %h, required c%0d s%0d a%0d d%0d @%0d %h",
                     act.cwe, act.swe, act.ack, act.dn, act.addr, act.data,
                     ex.cwe, ex.swe, ex.ack, ex.dn, ex.addr, ex.data);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_paint(input int x, input int y, input logic px, input bit chk_lat);
    logic [COLS-1:0] r;
    int  cnt;
    bit  got, inr;
    inr = (x < COLS) && (y < ROWS);
    if (inr) begin
      r = ref_canvas[y];
      r[x] = px;
      ref_canvas[y] = r;
      exp_q.push_back(mk(1, 0, 1, 0, y, r));
    end else begin
      exp_q.push_back(mk(0, 0, 1, 0, 0, '0));
    end
    paint_x = 11'(x); paint_y = 11'(y); paint_px = px; paint_we = 1'b1;
    cnt = 0; got = 0;
    while (!got && cnt < 3000) begin
      @(negedge CLOCK_50);
      got = paint_ack;
      step();
      cnt++;
    end
    paint_we = 1'b0;
    if (!got) check("paint_timeout", 0, 1);
    else if (chk_lat) check("paint_latency", cnt - 1, inr ? 2 : 1);
  endtask

  task automatic do_op(input bit is_save);
    int cnt;
    bit got, busy_bad;
    for (int r = 0; r < ROWS; r++) begin
      if (is_save) exp_q.push_back(mk(0, 1, 0, 0, r, ref_canvas[r]));
      else         exp_q.push_back(mk(1, 0, 0, 0, r, ref_save[r]));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 0, '0));
    if (is_save) begin ref_save = ref_canvas; ref_valid = 1; end
    else         ref_canvas = ref_save;
    save_req = is_save; load_req = !is_save;
    cnt = 0; got = 0; busy_bad = 0;
    while (!got && cnt < 3000) begin
      @(negedge CLOCK_50);
      got = done;
      if (cnt >= 1 && !got && !busy) busy_bad = 1;
      step();
      save_req = 1'b0; load_req = 1'b0;
      cnt++;
    end
    check(is_save ? "save_done_cycle" : "load_done_cycle", got ? cnt - 1 : -1, 2 * ROWS + 1);
    check("busy_during_op", busy_bad, 0);
    check("busy_after_op", busy, 0);
    check("save_valid_after_op", save_valid, 1);
  endtask

  initial begin
    int dcyc, acyc;
    bit bad;
    fork monitor(); join_none

    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_save_valid", save_valid, 0);
    check("rst_paint_ack", paint_ack, 0);
    check("rst_we", {canvas_we, save_we}, 0);
    check("rst_addr", {canvas_addr, save_addr}, 0);
    reset = 1'b0;

    for (int r = 0; r < ROWS; r++) begin
      ref_canvas[r] = (r == 5) ? '0 : rnd_row();
      bd_we = 1'b1; bd_addr = AW'(r); bd_data = ref_canvas[r];
      step();
    end
    bd_we = 1'b0;

    load_req = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      load_req = 1'b0;
      if (busy) bad = 1;
    end
    check("load_without_snapshot_busy", bad, 0);

    do_paint(3, 5, 1'b1, 1);
    do_paint(3, 5, 1'b0, 1);
    do_paint(640, 1, 1'b1, 1);
    do_paint(1, 480, 1'b1, 1);
    do_paint(639, 479, 1'b1, 1);
    do_paint(0, 0, 1'b1, 1);
    for (int i = 0; i < 20; i++)
      do_paint($urandom_range(0, 700), $urandom_range(0, 520), 1'($urandom), 1);

    do_op(1);

    for (int r = 0; r < 10; r++) exp_q.push_back(mk(0, 1, 0, 0, r, ref_canvas[r]));
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    #1;
    ref_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_save_valid", save_valid, 0);
    check("abort_rows_written", exp_q.size(), 0);
    step();
    reset = 1'b0;
    load_req = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      load_req = 1'b0;
      if (busy) bad = 1;
    end
    check("load_after_abort_busy", bad, 0);

    do_op(1);
    for (int y = 1; y <= 5; y++) do_paint($urandom_range(0, COLS - 1), y, 1'b1, 1);
    do_paint(17, 3, ~ref_canvas[3][17], 1);
    do_op(0);

    for (int r = 0; r < ROWS; r++) exp_q.push_back(mk(0, 1, 0, 0, r, ref_canvas[r]));
    exp_q.push_back(mk(0, 0, 0, 1, 0, '0));
    ref_save = ref_canvas;
    ref_canvas[7][100] = ~ref_canvas[7][100];
    exp_q.push_back(mk(1, 0, 1, 0, 7, ref_canvas[7]));
    save_req = 1'b1; load_req = 1'b1;
    paint_x = 11'd100; paint_y = 11'd7; paint_px = ref_canvas[7][100]; paint_we = 1'b1;
    dcyc = -1; acyc = -1;
    for (int c = 0; c < 3000 && acyc < 0; c++) begin
      @(negedge CLOCK_50);
      if (done) dcyc = c;
      if (paint_ack) acyc = c;
      step();
      save_req = 1'b0;
      load_req = (c == 99);
      if (acyc >= 0) paint_we = 1'b0;
    end
    paint_we = 1'b0; load_req = 1'b0;
    check("arb_done_cycle", dcyc, 2 * ROWS + 1);
    check("arb_ack_after_fin", acyc - dcyc, 3);
    repeat (5) step();
    check("arb_dropped_load_busy", busy, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
